// File: rtl/csr_access_sequencer.sv
// Owns the CSR file's single read/write port and sequences pipeline Zicsr
// accesses, trap entry and MRET as fixed multi-cycle read/write sequences.
module csr_access_sequencer #(
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_req,
  input  logic [1:0]  pipe_ops,
  input  logic        pipe_rd_req,
  input  logic        pipe_wr_req,
  input  logic [11:0] pipe_addr,
  input  logic [31:0] pipe_src,
  output logic        pipe_busy,
  output logic        pipe_done,
  output logic [31:0] pipe_rdata,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  output logic        trap_done,
  input  logic        mret_req,
  output logic        mret_done,
  output logic [31:0] mret_pc,
  output logic [11:0] csr_addr,
  output logic        csr_re,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata
);

  // state   | meaning
  // IDLE    | arbitrate trap > mret > pipe; pipe read issued here
  // P_RD    | pipe old value returned, optional read-modify-write
  // P_WR    | pipe write without read (or no-op completion)
  // T_EPC   | trap: write mepc
  // T_CAUSE | trap: write mcause
  // T_TVAL  | trap: write mtval
  // T_STRD  | trap: read mstatus
  // T_STWR  | trap: write updated mstatus, trap_done
  // M_EPC   | mret: read mepc
  // M_STRD  | mret: latch mepc, read mstatus
  // M_STWR  | mret: write updated mstatus, mret_done
  typedef enum logic [3:0] {
    IDLE, P_RD, P_WR, T_EPC, T_CAUSE, T_TVAL, T_STRD, T_STWR, M_EPC, M_STRD, M_STWR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pipe_rdata_q;
  logic [31:0] mret_pc_q;
  logic [31:0] pipe_new;
  logic [31:0] st_trap;
  logic [31:0] st_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pipe_rdata_q <= '0;
      mret_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == P_RD)
        pipe_rdata_q <= csr_rdata;
      else if (state_q == P_WR)
        pipe_rdata_q <= '0;
      if (state_q == M_STRD)
        mret_pc_q <= csr_rdata;
    end
  end

  always_comb begin
    unique case (pipe_ops)
      2'b10:   pipe_new = csr_rdata | pipe_src;
      2'b11:   pipe_new = csr_rdata & ~pipe_src;
      default: pipe_new = pipe_src;
    endcase
  end

  // mstatus: MIE = bit 3, MPIE = bit 7, MPP = bits 12:11
  always_comb begin
    st_trap        = csr_rdata;
    st_trap[7]     = csr_rdata[3];
    st_trap[3]     = 1'b0;
    st_trap[12:11] = 2'b11;
    st_mret        = csr_rdata;
    st_mret[3]     = csr_rdata[7];
    st_mret[7]     = 1'b1;
    st_mret[12:11] = 2'b11;
  end

  always_comb begin
    state_d    = state_q;
    csr_addr   = '0;
    csr_re     = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    pipe_done  = 1'b0;
    trap_done  = 1'b0;
    mret_done  = 1'b0;
    pipe_rdata = pipe_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (trap_req) begin
          state_d = T_EPC;
        end else if (mret_req) begin
          state_d = M_EPC;
        end else if (pipe_req) begin
          if (pipe_ops != 2'b00 && pipe_rd_req) begin
            csr_addr = pipe_addr;
            csr_re   = 1'b1;
            state_d  = P_RD;
          end else begin
            state_d = P_WR;
          end
        end
      end
      P_RD: begin
        csr_addr   = pipe_addr;
        csr_we     = pipe_wr_req;
        csr_wdata  = pipe_new;
        pipe_rdata = csr_rdata;
        pipe_done  = 1'b1;
        state_d    = IDLE;
      end
      P_WR: begin
        csr_addr   = pipe_addr;
        csr_we     = pipe_wr_req && (pipe_ops != 2'b00);
        csr_wdata  = pipe_src;
        pipe_rdata = '0;
        pipe_done  = 1'b1;
        state_d    = IDLE;
      end
      T_EPC: begin
        csr_addr  = MEPC_ADDR;
        csr_we    = 1'b1;
        csr_wdata = trap_pc;
        state_d   = T_CAUSE;
      end
      T_CAUSE: begin
        csr_addr  = MCAUSE_ADDR;
        csr_we    = 1'b1;
        csr_wdata = trap_cause;
        state_d   = T_TVAL;
      end
      T_TVAL: begin
        csr_addr  = MTVAL_ADDR;
        csr_we    = 1'b1;
        csr_wdata = trap_tval;
        state_d   = T_STRD;
      end
      T_STRD: begin
        csr_addr = MSTATUS_ADDR;
        csr_re   = 1'b1;
        state_d  = T_STWR;
      end
      T_STWR: begin
        csr_addr  = MSTATUS_ADDR;
        csr_we    = 1'b1;
        csr_wdata = st_trap;
        trap_done = 1'b1;
        state_d   = IDLE;
      end
      M_EPC: begin
        csr_addr = MEPC_ADDR;
        csr_re   = 1'b1;
        state_d  = M_STRD;
      end
      M_STRD: begin
        csr_addr = MSTATUS_ADDR;
        csr_re   = 1'b1;
        state_d  = M_STWR;
      end
      M_STWR: begin
        csr_addr  = MSTATUS_ADDR;
        csr_we    = 1'b1;
        csr_wdata = st_mret;
        mret_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the port must be silenced combinationally
    // during the reset cycle to keep an abandoned sequence from committing.
    if (rst) begin
      csr_addr   = '0;
      csr_re     = 1'b0;
      csr_we     = 1'b0;
      csr_wdata  = '0;
      pipe_done  = 1'b0;
      trap_done  = 1'b0;
      mret_done  = 1'b0;
      pipe_rdata = '0;
    end
    pipe_busy = pipe_req & ~pipe_done & ~rst;
  end

  assign mret_pc = mret_pc_q;

endmodule

// File: doc/csr_access_sequencer.md
Name: csr_access_sequencer

Overview:
- Single owner of the CSR register file's one read/write port.
- Arbitrates that port between three requesters: pipeline Zicsr instructions (from the EXE-stage read/write decode), the trap unit (exception/interrupt entry) and MRET.
- Sequences each request as fixed multi-cycle read-modify-write or write sequences, and returns old values and completion pulses.

Parameters:
- MEPC_ADDR, 12'h341, mepc address
- MCAUSE_ADDR, 12'h342, mcause address
- MTVAL_ADDR, 12'h343, mtval address
- MSTATUS_ADDR, 12'h300, mstatus address

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pipe_req  in  1  CSR instruction present; held until pipe_done
- pipe_ops  in  2  00 none, 01 write, 10 set, 11 clear
- pipe_rd_req  in  1  old value needed (rd != x0)
- pipe_wr_req  in  1  CSR must be written
- pipe_addr  in  12  CSR address
- pipe_src  in  32  rs1 value or zero-extended zimm
- pipe_busy  out  1  stall request to pipeline
- pipe_done  out  1  one-cycle completion pulse
- pipe_rdata  out  32  old CSR value, valid with pipe_done
- trap_req  in  1  trap entry request; held until trap_done
- trap_pc  in  32  value for mepc
- trap_cause  in  32  value for mcause
- trap_tval  in  32  value for mtval
- trap_done  out  1  one-cycle pulse
- mret_req  in  1  MRET request; held until mret_done
- mret_done  out  1  one-cycle pulse
- mret_pc  out  32  mepc value, valid with mret_done
- csr_addr  out  12  CSR file address
- csr_re  out  1  read enable; csr_rdata valid the following cycle
- csr_rdata  in  32  CSR file read data
- csr_we  out  1  write enable, committed at the clock edge
- csr_wdata  out  32  write data

Behaviour:
- Reset:
  - State is IDLE.
  - All pulses, csr_re, csr_we and pipe_busy are 0.
  - pipe_rdata and mret_pc are 0.
  - A reset in mid-sequence abandons the sequence; CSR writes already committed stay.
- States: IDLE, P_RD, P_WR, T_EPC, T_CAUSE, T_TVAL, T_STRD, T_STWR, M_EPC, M_STRD, M_STWR.
- IDLE arbitration: trap_req > mret_req > pipe_req. Requests are only accepted in IDLE; no preemption of a running sequence.
- Pipe accept in IDLE, cycle T:
  - pipe_ops == 00 with pipe_req: done at T+1, no CSR access, pipe_rdata = 0.
  - pipe_rd_req = 1: drive csr_re with pipe_addr at T, go to P_RD.
  - pipe_rd_req = 0: go to P_WR.
- P_RD (T+1):
  - pipe_rdata <= csr_rdata.
  - If pipe_wr_req: csr_we with new value, where write gives src, set gives old|src, clear gives old&~src.
  - pipe_done = 1, return to IDLE.
- P_WR (T+1): csr_we, csr_wdata = pipe_src (only write op reaches here with wr), pipe_done = 1, pipe_rdata = 0, return to IDLE.
- Pipe latency is always 1 cycle.
- pipe_busy = pipe_req & ~pipe_done, i.e. high while a pipe request is pending, including during trap/mret sequences.
- Trap sequence (accept at T):
  - T+1: write mepc = trap_pc.
  - T+2: write mcause.
  - T+3: write mtval.
  - T+4: read mstatus.
  - T+5: write mstatus with MPIE[7] <= MIE[3], MIE <= 0, MPP[12:11] <= 2'b11, other bits unchanged; trap_done = 1.
- MRET sequence (accept at T):
  - T+1: read mepc.
  - T+2: latch mret_pc, read mstatus.
  - T+3: write mstatus with MIE <= MPIE, MPIE <= 1, MPP <= 2'b11; mret_done = 1.
- Only one of csr_re / csr_we is asserted per cycle.
- When idle, csr_addr = 0.
- trap_req rising while a pipe sequence is in P_RD/P_WR: the pipe op completes, then the trap is taken the next IDLE cycle.
- Requests dropped before their done pulse are a protocol violation; behaviour is undefined.

Test Plan:
- CSRRW, mscratch = 0x11, src = 0xAA, rd_req = 1 -> read at T, write 0xAA at T+1, pipe_done at T+1, pipe_rdata = 0x11.
- CSRRS with rs1 = x0 (wr_req = 0), mscratch = 0xF0 -> no csr_we, pipe_rdata = 0xF0 at T+1; CSRRC src = 0x30 on 0xF0 -> writes 0xC0.
- CSRRW with rd = x0 (rd_req = 0), src = 5 -> no csr_re, single write of 5 at T+1, pipe_rdata = 0.
- Trap with mstatus = 0x8, pc = 0x100, cause = 2, tval = 0xDEAD -> writes in order at T+1..T+3, mstatus = 0x1880 at T+5, trap_done at T+5.
- trap_req, mret_req and pipe_req in the same cycle -> trap runs first, then MRET (mstatus 0x1880 -> 0x1888, mret_pc = 0x100), then pipe; pipe_busy high throughout.
- rst asserted at T+2 of a trap -> IDLE next cycle, no further writes, trap_done never pulses, mepc keeps 0x100.
